icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/icache_if.sv | 28 ++
 rtl/icache.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU cache types.
// Contents: instruction-cache address split (icachef_t), geometry constants
// and the instruction-cache controller state encoding.
package cpu_types_pkg;

    localparam int ITAG_W     = 25;
    localparam int IIDX_W     = 4;
    localparam int IBLK_WORDS = 2;

    // imemaddr viewed as cache fields: [31:7] tag, [6:3] set, [2] word, [1:0] byte
    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic              blkoff;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH0,
        FETCH1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Instruction cache bus bundle.
// Datapath side : imemREN, imemaddr (request), ihit, imemload (response).
// Controller side: iREN, iaddr (request), iwait, iload (response).
// modport slave  : the cache's view.
// modport master : the environment's view (datapath + memory controller).
interface icache_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;

    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, 16 sets x 2 words, read-only.
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - icache_if.slave: datapath request/response and memory
//          controller request/response (see icache_if.sv)
// A hit is answered combinationally in IDLE. A miss fetches both words of
// the block (FETCH0 then FETCH1) from the controller and returns to IDLE.
import cpu_types_pkg::*;

module icache (
    input logic      CLK,
    input logic      nRST,
    icache_if.slave  bus
);

    localparam int unsigned NSETS = 2 ** IIDX_W;

    icache_state_t     state;
    logic [ITAG_W-1:0] miss_tag;
    logic [IIDX_W-1:0] miss_idx;
    logic [NSETS-1:0]  valid;
    logic              iren_q;
    logic [31:0]       iaddr_q;

    logic [ITAG_W-1:0] tags [NSETS];
    logic [31:0]       data [NSETS][IBLK_WORDS];

    icachef_t req;
    logic     hit;
    logic     unused_bytoff;

    assign req           = icachef_t'(bus.imemaddr);
    assign unused_bytoff = ^req.bytoff;

    always_comb begin
        hit = (state == IDLE) && bus.imemREN && valid[req.idx]
              && (tags[req.idx] == req.tag);
    end

    assign bus.ihit     = hit;
    assign bus.imemload = hit ? data[req.idx][req.blkoff] : '0;
    assign bus.iREN     = iren_q;
    assign bus.iaddr    = iaddr_q;

    // Controller state, miss register and valid bits. iREN/iaddr are
    // registered and loaded on the transition into each fetch state, so they
    // equal the state-decoded values without a combinational output path.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            miss_tag <= '0;
            miss_idx <= '0;
            valid    <= '0;
            iren_q   <= 1'b0;
            iaddr_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.imemREN && !hit) begin
                        miss_tag       <= req.tag;
                        miss_idx       <= req.idx;
                        // invalidate now so a half-filled block never hits
                        valid[req.idx] <= 1'b0;
                        iren_q         <= 1'b1;
                        iaddr_q        <= {req.tag, req.idx, 1'b0, 2'b00};
                        state          <= FETCH0;
                    end
                end
                FETCH0: begin
                    if (!bus.iwait) begin
                        iaddr_q <= {miss_tag, miss_idx, 1'b1, 2'b00};
                        state   <= FETCH1;
                    end
                end
                FETCH1: begin
                    if (!bus.iwait) begin
                        valid[miss_idx] <= 1'b1;
                        iren_q          <= 1'b0;
                        iaddr_q         <= '0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data storage is not reset; valid bits alone guard it.
    always_ff @(posedge CLK) begin
        if (state == FETCH0 && !bus.iwait) begin
            data[miss_idx][0] <= bus.iload;
        end
        if (state == FETCH1 && !bus.iwait) begin
            data[miss_idx][1] <= bus.iload;
            tags[miss_idx]    <= miss_tag;
        end
    end

endmodule
